// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_decoder
// Purpose  : Measures servo PWM high time and decodes it into a 2-bit position
//            code with glitch, signal-loss and lock indication.
// Revision : 1.0
// ============================================================================
module servo_pwm_decoder #(
   parameter int CNT_W      = 21,
   parameter int MIN_WIDTH  = 13500,
   parameter int MAX_WIDTH  = 150000,
   parameter int TH01       = 39500,
   parameter int TH12       = 64500,
   parameter int TH23       = 102500,
   parameter int TIMEOUT    = 1100000,
   parameter int LOCK_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [1:0]       pos,
   output logic             pos_valid,
   output logic [CNT_W-1:0] width,
   output logic             glitch,
   output logic             timeout,
   output logic             locked
);

   localparam int               c_LOCK_W  = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] c_MIN     = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0] c_MAX     = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] c_SAT     = CNT_W'(MAX_WIDTH + 1);
   localparam logic [CNT_W-1:0] c_TH01    = CNT_W'(TH01);
   localparam logic [CNT_W-1:0] c_TH12    = CNT_W'(TH12);
   localparam logic [CNT_W-1:0] c_TH23    = CNT_W'(TH23);
   localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [c_LOCK_W-1:0] c_LOCK = c_LOCK_W'(LOCK_COUNT);
   localparam logic [c_LOCK_W-1:0] c_ONE  = c_LOCK_W'(1);

   typedef enum logic [1:0] {
      ST_ARM  = 2'd0,
      ST_IDLE = 2'd1,
      ST_HIGH = 2'd2,
      ST_EVAL = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_sync1;
   logic                r_s;
   logic                r_s_d;
   logic                w_rise;
   logic                w_fall;
   logic                w_expire;
   logic                w_eval;
   logic                w_in_range;
   logic [1:0]          w_code;
   logic [CNT_W-1:0]    r_hcnt;
   logic [CNT_W-1:0]    r_tcnt;
   logic [c_LOCK_W-1:0] r_stable;
   logic [c_LOCK_W-1:0] w_stable_next;

   function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
      if (w < c_TH01)      return 2'b00;
      else if (w < c_TH12) return 2'b01;
      else if (w < c_TH23) return 2'b10;
      else                 return 2'b11;
   endfunction

   // Synchronizer is deliberately left out of reset so that ARM sees the true
   // line level immediately and never mistakes a held-high input for a rise.
   always_ff @(posedge clk) begin
      r_sync1 <= pwm_in;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
   end

   assign w_rise     = r_s & ~r_s_d;
   assign w_fall     = ~r_s & r_s_d;
   assign w_expire   = (r_state != ST_ARM) && !w_rise && (r_tcnt >= c_TO_LAST);
   assign w_in_range = (r_hcnt >= c_MIN) && (r_hcnt <= c_MAX);
   assign w_code     = classify(r_hcnt);

   always_comb begin
      w_stable_next = c_ONE;
      if (w_code == pos) begin
         if (r_stable >= c_LOCK) w_stable_next = r_stable;
         else                    w_stable_next = r_stable + c_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_ARM;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_eval       = 1'b0;
      if (w_expire) begin
         w_state_next = ST_ARM;
      end else begin
         case (r_state)
            ST_ARM:  if (!r_s)   w_state_next = ST_IDLE;
            ST_IDLE: if (w_rise) w_state_next = ST_HIGH;
            ST_HIGH: if (w_fall) w_state_next = ST_EVAL;
            ST_EVAL: begin
               w_state_next = ST_IDLE;
               w_eval       = 1'b1;
            end
            default: w_state_next = ST_ARM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcnt    <= '0;
         r_tcnt    <= '0;
         r_stable  <= '0;
         pos       <= 2'b00;
         pos_valid <= 1'b0;
         width     <= '0;
         glitch    <= 1'b0;
         timeout   <= 1'b0;
         locked    <= 1'b0;
      end else begin
         pos_valid <= 1'b0;
         glitch    <= 1'b0;

         if (r_state == ST_ARM || w_rise) r_tcnt <= '0;
         else if (r_tcnt != '1)           r_tcnt <= r_tcnt + 1'b1;

         // Counting the rise cycle itself keeps width equal to the high time.
         if (r_state == ST_IDLE && w_rise)
            r_hcnt <= CNT_W'(1);
         else if (r_state == ST_HIGH && r_s && r_hcnt < c_SAT)
            r_hcnt <= r_hcnt + 1'b1;

         if (w_expire)
            timeout <= 1'b1;
         else if (r_state == ST_IDLE && w_rise)
            timeout <= 1'b0;

         if (w_expire) begin
            r_stable <= '0;
            locked   <= 1'b0;
         end else if (w_eval) begin
            width <= r_hcnt;
            if (w_in_range) begin
               pos       <= w_code;
               pos_valid <= 1'b1;
               r_stable  <= w_stable_next;
               locked    <= (w_stable_next >= c_LOCK);
            end else begin
               glitch   <= 1'b1;
               r_stable <= '0;
               locked   <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_decoder
// Purpose  : Directed self-checking bench for servo_pwm_decoder using widths
//            and timeout scaled down by 100 through the parameters.
// Revision : 1.0
// ============================================================================
module tb_servo_pwm_decoder;

   localparam int CNT_W   = 21;
   localparam int TIMEOUT = 11000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_in = 1'b1;
   logic [1:0]       pos;
   logic             pos_valid;
   logic [CNT_W-1:0] width;
   logic             glitch;
   logic             timeout;
   logic             locked;

   int n_pass  = 0;
   int n_total = 0;
   int n_valid = 0;
   int n_glitch = 0;
   int snap_v;
   int snap_g;

   servo_pwm_decoder #(
      .CNT_W(CNT_W), .MIN_WIDTH(135), .MAX_WIDTH(1500), .TH01(395),
      .TH12(645), .TH23(1025), .TIMEOUT(TIMEOUT), .LOCK_COUNT(3)
   ) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in), .pos(pos), .pos_valid(pos_valid),
      .width(width), .glitch(glitch), .timeout(timeout), .locked(locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pos_valid) n_valid++;
      if (glitch)    n_glitch++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // High for hi cycles, then low for lo cycles; returns at posedge+1.
   task automatic send(input int hi, input int lo);
      pwm_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic send_code(input string tag, input int hi, input logic [1:0] exp_pos,
                            input logic exp_lock);
      snap_v = n_valid;
      send(hi, 300);
      chk({tag, "_valid"}, n_valid, snap_v + 1);
      chk({tag, "_pos"}, {30'd0, pos}, {30'd0, exp_pos});
      chk({tag, "_width"}, width, hi);
      chk({tag, "_locked"}, {31'd0, locked}, {31'd0, exp_lock});
   endtask

   initial begin
      // Reset with the input held high
      repeat (5) @(posedge clk);
      #1;
      chk("rst_pos", {30'd0, pos}, 0);
      chk("rst_valid", {31'd0, pos_valid}, 0);
      chk("rst_width", width, 0);
      chk("rst_glitch", {31'd0, glitch}, 0);
      chk("rst_timeout", {31'd0, timeout}, 0);
      chk("rst_locked", {31'd0, locked}, 0);
      rst = 1'b0;
      repeat (300) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      chk("arm_novalid", n_valid, 0);
      chk("arm_noglitch", n_glitch, 0);
      chk("arm_width", width, 0);

      // Lock acquisition on code 01
      send_code("lock1", 520, 2'b01, 1'b0);
      send_code("lock2", 520, 2'b01, 1'b0);
      send_code("lock3", 520, 2'b01, 1'b1);

      // Width sweep including the TH01 boundary
      send_code("sw270", 270, 2'b00, 1'b0);
      send_code("sw770", 770, 2'b10, 1'b0);
      send_code("sw1280", 1280, 2'b11, 1'b0);
      send_code("sw394", 394, 2'b00, 1'b0);
      send_code("sw395", 395, 2'b01, 1'b0);
      send_code("sw520a", 520, 2'b01, 1'b0);
      send_code("sw520b", 520, 2'b01, 1'b1);

      // Too short and too long pulses
      snap_v = n_valid; snap_g = n_glitch;
      send(50, 300);
      chk("short_glitch", n_glitch, snap_g + 1);
      chk("short_novalid", n_valid, snap_v);
      chk("short_width", width, 50);
      chk("short_pos", {30'd0, pos}, 1);
      chk("short_locked", {31'd0, locked}, 0);
      send(2000, 300);
      chk("long_glitch", n_glitch, snap_g + 2);
      chk("long_novalid", n_valid, snap_v);
      chk("long_width", width, 1501);
      chk("long_pos", {30'd0, pos}, 1);

      // Relock, then lose the signal while low
      send_code("rl1", 520, 2'b01, 1'b0);
      send_code("rl2", 520, 2'b01, 1'b0);
      send_code("rl3", 520, 2'b01, 1'b1);
      repeat (TIMEOUT - 50 - 820) @(posedge clk);
      #1;
      chk("to_early", {31'd0, timeout}, 0);
      chk("to_early_lock", {31'd0, locked}, 1);
      repeat (100) @(posedge clk);
      #1;
      chk("to_fired", {31'd0, timeout}, 1);
      chk("to_locked", {31'd0, locked}, 0);
      chk("to_pos", {30'd0, pos}, 1);
      repeat (1000) @(posedge clk);
      #1;
      chk("to_hold", {31'd0, timeout}, 1);
      send_code("to_recover", 1280, 2'b11, 1'b0);
      chk("to_cleared", {31'd0, timeout}, 0);

      // Input stuck high: timeout from HIGH without evaluation
      snap_v = n_valid; snap_g = n_glitch;
      pwm_in = 1'b1;
      repeat (TIMEOUT + 100) @(posedge clk);
      #1;
      chk("stuck_timeout", {31'd0, timeout}, 1);
      chk("stuck_novalid", n_valid, snap_v);
      chk("stuck_noglitch", n_glitch, snap_g);
      pwm_in = 1'b0;
      repeat (300) @(posedge clk);
      #1;

      // Alternating codes never lock; three equal codes do
      send_code("alt00a", 270, 2'b00, 1'b0);
      chk("stuck_cleared", {31'd0, timeout}, 0);
      send_code("alt11", 1280, 2'b11, 1'b0);
      send_code("alt00b", 270, 2'b00, 1'b0);
      send_code("run11a", 1280, 2'b11, 1'b0);
      send_code("run11b", 1280, 2'b11, 1'b0);
      send_code("run11c", 1280, 2'b11, 1'b1);

      // One-cycle reset in the middle of a pulse
      snap_v = n_valid;
      pwm_in = 1'b1;
      repeat (200) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_pos", {30'd0, pos}, 0);
      chk("mid_rst_locked", {31'd0, locked}, 0);
      chk("mid_rst_width", width, 0);
      repeat (569) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      chk("mid_rst_novalid", n_valid, snap_v);
      chk("mid_rst_width2", width, 0);
      send_code("post_rst", 770, 2'b10, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receives a servo-style PWM signal (one high pulse per ~20 ms frame at 50 MHz) and measures the high time of each pulse in clk cycles.
- Classifies each measured width into a 2-bit position code and reports it with a one-cycle valid strobe.
- Sits at the input side of the servo path. It decodes the 27000/52000/77000/128000-cycle pulse widths that the team's servo PWM generator drives for switch codes 00/01/10/11.
- Also flags malformed pulses and loss of signal.

Parameters:
- CNT_W, 21, width of the width and period counters.
- MIN_WIDTH, 13500, shortest accepted pulse in cycles; shorter pulses are glitches.
- MAX_WIDTH, 150000, longest accepted pulse in cycles; longer pulses are errors.
- TH01, 39500, boundary between code 00 and code 01 (width < TH01 gives 00).
- TH12, 64500, boundary between code 01 and code 10.
- TH23, 102500, boundary between code 10 and code 11.
- TIMEOUT, 1100000, cycles without a rising edge before signal loss is declared.
- LOCK_COUNT, 3, number of consecutive identical valid codes required to assert locked.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; see Behaviour.
- pwm_in  in  1  asynchronous PWM input.
- pos  out  2  last accepted position code.
- pos_valid  out  1  one-cycle strobe when pos updates.
- width  out  CNT_W  last measured high time in cycles, valid or not.
- glitch  out  1  one-cycle strobe when a pulse is rejected (too short or too long).
- timeout  out  1  level; asserted while the input is considered lost.
- locked  out  1  level; asserted when the code is stable.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- On reset, all outputs are 0: pos=0, pos_valid=0, width=0, glitch=0, timeout=0, locked=0. State goes to ARM and all counters clear.
- Input conditioning: pwm_in passes through a 2-flop synchronizer, giving s. A third flop provides s_d for edge detection.
  - rise = s & ~s_d.
  - fall = ~s & s_d.
- FSM states and transitions:
  - ARM: wait for s==0, then go to IDLE. This prevents measuring a partial pulse after reset or after a timeout that occurred while the input was high.
  - IDLE: wait for rise. On rise, set hcnt=1 and go to HIGH.
  - HIGH: hcnt increments each cycle while s==1, saturating at MAX_WIDTH+1. On fall, go to EVAL.
  - EVAL (one cycle): width <= hcnt.
    - If hcnt < MIN_WIDTH or hcnt > MAX_WIDTH: pulse glitch, leave pos unchanged, clear the lock counter.
    - Otherwise: pos <= code(hcnt), pulse pos_valid, update the lock counter.
    - Then go to IDLE.
- Classification: code = 00 if w < TH01; 01 if w < TH12; 10 if w < TH23; else 11. Comparisons are unsigned.
- Latency: pos_valid asserts exactly 2 clk cycles after the cycle in which fall is seen, which is 4 cycles after the pwm_in falling edge.
- Width accuracy: the measured width equals the pwm_in high time ±1 cycle.
- Lock logic:
  - A stable counter increments when a new valid code equals the previous valid code. It resets to 1 on a different code.
  - locked=1 when the counter reaches LOCK_COUNT.
  - Any glitch or timeout clears the counter and locked.
- Timeout:
  - tcnt counts cycles since the last rise in every state except ARM. It is cleared on rise.
  - When tcnt reaches TIMEOUT: timeout<=1, locked<=0, pos holds its value, and state goes to ARM.
  - timeout clears on the next rise seen from IDLE.
  - If the input is stuck high, the timeout fires from HIGH with no EVAL.
- Simultaneous events: if rise and the tcnt expiry occur in the same cycle, rise wins (tcnt clears, no timeout).
- Reset mid-pulse: the partial pulse is discarded and the first complete pulse after the input goes low is measured.

Test Plan:
- Reset with pwm_in=1 held, then drive 52000-cycle pulses at a 1,000,001-cycle period -> the first pulse is ignored (ARM). Then pos=01 and pos_valid strobes each frame, width=52000±1, locked=1 after the 3rd valid strobe.
- Sweep widths 27000, 77000, 128000, 39499, 39500 -> pos = 00, 10, 11, 00, 01 respectively.
- 5000-cycle pulse and 200000-cycle pulse -> glitch strobes, pos unchanged, locked=0, width=5000 and 150001 respectively.
- Hold pwm_in=0 for 1,200,000 cycles after lock -> timeout=1 at cycle 1,100,000 after the last rise, locked=0, pos held. The next valid pulse clears timeout.
- Alternate codes 00, 11, 00 -> locked never asserts. Then three 11 pulses -> locked=1.
- Assert rst for one cycle mid-pulse (at 20000 cycles into a 77000-cycle pulse) -> outputs 0 and no pos_valid for that pulse. The next full pulse gives pos=10.
